sonar_scheduler: RTL and testbench



---
 rtl/sonar_scheduler_if.sv | 23 ++
 rtl/sonar_scheduler.sv | 103 ++++++++++
 tb/tb_sonar_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sonar_scheduler_if.sv
// sonar_scheduler_if: host config, capture-path and sonar-pin signals of sonar_scheduler
interface sonar_scheduler_if #(parameter int NCH = 4);
  localparam int CW = $clog2(NCH);
  logic              us_tick;
  logic              cfg_en;
  logic [NCH-1:0]    cfg_mask;
  logic              meas_valid;
  logic [15:0]       meas_width;
  logic [NCH-1:0]    sonar_en;
  logic [CW-1:0]     cap_sel;
  logic [16*NCH-1:0] dist_bus;
  logic [NCH-1:0]    ch_fresh;
  logic [NCH-1:0]    ch_timeout;
  logic              frame_done;
  modport master (
    output us_tick, cfg_en, cfg_mask, meas_valid, meas_width,
    input  sonar_en, cap_sel, dist_bus, ch_fresh, ch_timeout, frame_done
  );
  modport slave (
    input  us_tick, cfg_en, cfg_mask, meas_valid, meas_width,
    output sonar_en, cap_sel, dist_bus, ch_fresh, ch_timeout, frame_done
  );
endinterface

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin one-at-a-time sonar enable with shared capture; SONAR_HOLD_LAST_EN keeps dist on timeout
module sonar_scheduler #(
  parameter int NCH        = 4,
  parameter int GAP_US     = 10000,
  parameter int TIMEOUT_US = 60000
) (
  input logic clk,
  input logic rst_n,
  sonar_scheduler_if.slave bus
);
  localparam int CW = $clog2(NCH);
  typedef enum logic [2:0] {IDLE, GAP, RANGE, STORE, NEXT} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  ch_q, ch_d, start, sel;
  logic [NCH-1:0] rot;
  logic [15:0]    us_cnt_q, us_cnt_d;
  logic [NCH-1:0] sonar_en_q, sonar_en_d, fresh_q, fresh_d, tmo_q, tmo_d;
  logic [15:0]    dist_q [NCH];
  logic [15:0]    dist_d [NCH];
  logic           done_q, done_d, meas, tmo_hit;
  // channel choice is made on the edge into NEXT so cap_sel is already valid during NEXT
  always_comb begin
    start = (state_q == STORE && ch_q != CW'(NCH-1)) ? ch_q + 1'b1 : '0;
    rot = NCH'({bus.cfg_mask, bus.cfg_mask} >> start);
    sel = ch_q;
    for (int k = NCH-1; k >= 0; k--)
      if (rot[k]) sel = CW'((int'(start) + k) % NCH);
    meas = bus.cfg_en && state_q == RANGE && bus.meas_valid;
    tmo_hit = bus.cfg_en && state_q == RANGE && bus.us_tick && us_cnt_q == 16'(TIMEOUT_US-1);
    state_d = state_q;
    ch_d = ch_q;
    us_cnt_d = us_cnt_q;
    if (!bus.cfg_en) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (|bus.cfg_mask) begin
          state_d = NEXT;
          ch_d = sel;
        end
        NEXT: begin
          state_d = (|bus.cfg_mask) ? GAP : IDLE;
          us_cnt_d = '0;
        end
        GAP: if (bus.us_tick) begin
          state_d = (us_cnt_q == 16'(GAP_US-1)) ? RANGE : GAP;
          us_cnt_d = (us_cnt_q == 16'(GAP_US-1)) ? '0 : us_cnt_q + 1'b1;
        end
        RANGE: begin
          us_cnt_d = bus.us_tick ? us_cnt_q + 1'b1 : us_cnt_q;
          state_d = (meas || tmo_hit) ? STORE : RANGE;
        end
        STORE: begin
          state_d = NEXT;
          ch_d = sel;
        end
        default: state_d = IDLE;
      endcase
    sonar_en_d = (state_d == RANGE) ? NCH'(1) << ch_d : '0;
    fresh_d = (meas || tmo_hit) ? NCH'(1) << ch_q : '0;
    done_d = (meas || tmo_hit) && ((bus.cfg_mask >> ch_q) >> 1) == '0;
    tmo_d = tmo_q;
    dist_d = dist_q;
    if (meas) begin
      dist_d[ch_q] = bus.meas_width;
      tmo_d[ch_q] = 1'b0;
    end else if (tmo_hit) begin
      tmo_d[ch_q] = 1'b1;
`ifdef SONAR_HOLD_LAST_EN
      dist_d[ch_q] = dist_q[ch_q];
`else
      dist_d[ch_q] = 16'hFFFF;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q <= '0;
      us_cnt_q <= '0;
      sonar_en_q <= '0;
      fresh_q <= '0;
      tmo_q <= '0;
      done_q <= 1'b0;
      dist_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      us_cnt_q <= us_cnt_d;
      sonar_en_q <= sonar_en_d;
      fresh_q <= fresh_d;
      tmo_q <= tmo_d;
      done_q <= done_d;
      dist_q <= dist_d;
    end
  assign bus.sonar_en = sonar_en_q;
  assign bus.cap_sel = ch_q;
  assign bus.ch_fresh = fresh_q;
  assign bus.ch_timeout = tmo_q;
  assign bus.frame_done = done_q;
  for (genvar i = 0; i < NCH; i++) begin : g_dist
    assign bus.dist_bus[16*i +: 16] = dist_q[i];
  end
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed checks of sonar_scheduler with NCH=4, GAP_US=4, TIMEOUT_US=20, us_tick every 10 clk
module tb_sonar_scheduler;
  localparam int NCH = 4;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0, n_fail = 0;
  int   tcnt = 0, multi = 0, en1_len = 0;
  int   fresh_cnt [NCH] = '{default: 0};
  sonar_scheduler_if #(.NCH(NCH)) bus ();
  sonar_scheduler #(.NCH(NCH), .GAP_US(4), .TIMEOUT_US(20)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    bus.us_tick = (tcnt == 9);
  end
  always @(negedge clk) begin
    if ($countones(bus.sonar_en) > 1) multi++;
    if (bus.sonar_en[1]) en1_len++;
    for (int i = 0; i < NCH; i++) if (bus.ch_fresh[i]) fresh_cnt[i]++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] dist_of(input int c);
    return bus.dist_bus[16*c +: 16];
  endfunction
  task automatic wait_en(output int chn);
    int n = 0;
    while (bus.sonar_en == '0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("en_seen", bus.sonar_en != '0, 1);
    chn = -1;
    for (int i = 0; i < NCH; i++) if (bus.sonar_en[i]) chn = i;
  endtask
  task automatic pulse_meas(input logic [15:0] w);
    bus.meas_valid = 1'b1;
    bus.meas_width = w;
    @(negedge clk);
    bus.meas_valid = 1'b0;
  endtask
  task automatic range_meas(input int exp_ch, input int next_ch, input logic exp_done, input logic [15:0] w);
    int chn;
    wait_en(chn);
    check("order", chn, exp_ch);
    repeat (50) @(negedge clk);
    pulse_meas(w);
    check("fresh", bus.ch_fresh, 64'(1) << exp_ch);
    check("en_off", bus.sonar_en, 0);
    check("frame_done", bus.frame_done, exp_done);
    check("dist", dist_of(exp_ch), w);
    @(negedge clk);
    check("cap_sel", bus.cap_sel, next_ch);
  endtask
  initial begin
    int chn, base, f1, f3, n;
    logic [15:0] exp_to;
    rst_n = 1'b0;
    bus.cfg_en = 1'b0;
    bus.cfg_mask = '0;
    bus.meas_valid = 1'b0;
    bus.meas_width = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_en", bus.sonar_en, 0);
    check("rst_sel", bus.cap_sel, 0);
    check("rst_dist", bus.dist_bus, 0);
    check("rst_fresh", bus.ch_fresh, 0);
    check("rst_tmo", bus.ch_timeout, 0);
    check("rst_done", bus.frame_done, 0);
    pulse_meas(16'd55);
    @(negedge clk);
    check("idle_dist", bus.dist_bus, 0);
    check("idle_fresh", fresh_cnt[0] + fresh_cnt[1] + fresh_cnt[2] + fresh_cnt[3], 0);
    bus.cfg_mask = 4'b1111;
    bus.cfg_en = 1'b1;
    for (int r = 0; r < 5; r++)
      range_meas(r % 4, (r + 1) % 4, (r % 4) == 3, 16'(100 + r % 4));
    check("dist_all", bus.dist_bus, {16'd103, 16'd102, 16'd101, 16'd100});
    check("one_hot", multi, 0);
    bus.cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    bus.cfg_mask = 4'b0101;
    f1 = fresh_cnt[1];
    f3 = fresh_cnt[3];
    bus.cfg_en = 1'b1;
    for (int r = 0; r < 4; r++)
      range_meas((r % 2) * 2, ((r + 1) % 2) * 2, (r % 2) == 1, 16'(200 + r));
    check("keep1", dist_of(1), 101);
    check("keep3", dist_of(3), 103);
    check("fresh1", fresh_cnt[1] - f1, 0);
    check("fresh3", fresh_cnt[3] - f3, 0);
    check("dist0", dist_of(0), 202);
    check("dist2", dist_of(2), 203);
    bus.cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    bus.cfg_mask = 4'b0010;
    base = en1_len;
    bus.cfg_en = 1'b1;
    wait_en(chn);
    check("to_order", chn, 1);
    n = 0;
    while (bus.sonar_en != '0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("to_len", en1_len - base, 200);
    check("to_fresh", bus.ch_fresh, 4'b0010);
    check("to_flag", bus.ch_timeout, 4'b0010);
    check("to_done", bus.frame_done, 1);
`ifdef SONAR_HOLD_LAST_EN
    exp_to = 16'd101;
`else
    exp_to = 16'hFFFF;
`endif
    check("to_dist", dist_of(1), exp_to);
    wait_en(chn);
    check("tie_order", chn, 1);
    repeat (199) @(negedge clk);
    pulse_meas(16'd400);
    check("tie_fresh", bus.ch_fresh, 4'b0010);
    check("tie_dist", dist_of(1), 400);
    check("tie_flag", bus.ch_timeout, 0);
    wait_en(chn);
    repeat (30) @(negedge clk);
    bus.cfg_en = 1'b0;
    f1 = fresh_cnt[1];
    @(negedge clk);
    check("stop_en", bus.sonar_en, 0);
    check("stop_fresh", bus.ch_fresh, 0);
    pulse_meas(16'd77);
    repeat (3) @(negedge clk);
    check("stop_dist", dist_of(1), 400);
    check("stop_cnt", fresh_cnt[1] - f1, 0);
    check("stop_idle", bus.sonar_en, 0);
    bus.cfg_mask = 4'b1111;
    bus.cfg_en = 1'b1;
    wait_en(chn);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_en", bus.sonar_en, 0);
    check("arst_sel", bus.cap_sel, 0);
    check("arst_dist", bus.dist_bus, 0);
    check("arst_tmo", bus.ch_timeout, 0);
    check("arst_fresh", bus.ch_fresh, 0);
    check("arst_done", bus.frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
